// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for a single-bus fetch/execute datapath.
// Steps T0..T7 plus a terminal HALT; every control decodes from registered state and the IR opcode.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        Write,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        BAout,
    output logic        Rin,
    output logic        Rout,
    output logic        ADD,
    output logic        SUB,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Cout,
    output logic        Run,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd15
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic read;
        logic write;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic ba_out;
        logic r_in;
        logic r_out;
        logic add;
        logic sub;
        logic gra;
        logic grb;
        logic grc;
        logic c_out;
    } ctrl_t;

    state_e     state_q, state_d;
    logic       stop_q, stop_d;
    logic       live_q, live_d;
    logic [4:0] opcode;
    logic       stop_seen;
    logic       last_step;
    logic       halt_instr;
    logic       unused_ir_bits;
    ctrl_t      ctrl;

    assign opcode         = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];
    assign stop_seen      = stop_q | Stop;

    // live_q stays low from clr until the first edge after release, so T0 controls
    // appear on that edge rather than the moment clr drops.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= T0;
            stop_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            live_q  <= live_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        stop_d     = stop_seen;
        live_d     = 1'b1;
        last_step  = 1'b0;
        halt_instr = 1'b0;

        if (live_q) begin
            case (state_q)
                T0: state_d = T1;
                T1: state_d = T2;
                T2: state_d = T3;
                T3: begin
                    case (opcode)
                        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB: state_d = T4;
                        OP_HALT: begin
                            last_step  = 1'b1;
                            halt_instr = 1'b1;
                        end
                        default: last_step = 1'b1;
                    endcase
                end
                T4: state_d = T5;
                T5: begin
                    if (opcode == OP_LD || opcode == OP_ST) begin
                        state_d = T6;
                    end else begin
                        last_step = 1'b1;
                    end
                end
                T6: state_d = T7;
                T7: last_step = 1'b1;
                HALT: stop_d = 1'b0;
                default: state_d = T0;
            endcase

            // A pending Stop turns the instruction boundary into HALT.
            if (last_step) begin
                state_d = (stop_seen || halt_instr) ? HALT : T0;
                stop_d  = 1'b0;
            end
        end
    end

    always_comb begin
        ctrl = '0;
        if (live_q) begin
            case (state_q)
                T0: begin
                    ctrl.pc_out = 1'b1;
                    ctrl.mar_in = 1'b1;
                end
                T1: begin
                    ctrl.inc_pc = 1'b1;
                    ctrl.read   = 1'b1;
                    ctrl.mdr_in = 1'b1;
                end
                T2: begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.ir_in   = 1'b1;
                end
                T3: begin
                    case (opcode)
                        OP_LD, OP_LDI, OP_ST: begin
                            ctrl.grb    = 1'b1;
                            ctrl.ba_out = 1'b1;
                            ctrl.y_in   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.grb   = 1'b1;
                            ctrl.r_out = 1'b1;
                            ctrl.y_in  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_LD, OP_LDI, OP_ST: begin
                            ctrl.c_out = 1'b1;
                            ctrl.add   = 1'b1;
                            ctrl.z_in  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.grc   = 1'b1;
                            ctrl.r_out = 1'b1;
                            ctrl.add   = (opcode == OP_ADD);
                            ctrl.sub   = (opcode == OP_SUB);
                            ctrl.z_in  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LD, OP_ST: begin
                            ctrl.zlow_out = 1'b1;
                            ctrl.mar_in   = 1'b1;
                        end
                        OP_LDI, OP_ADD, OP_SUB: begin
                            ctrl.zlow_out = 1'b1;
                            ctrl.gra      = 1'b1;
                            ctrl.r_in     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_LD: begin
                            ctrl.read   = 1'b1;
                            ctrl.mdr_in = 1'b1;
                        end
                        OP_ST: begin
                            ctrl.gra    = 1'b1;
                            ctrl.ba_out = 1'b1;
                            ctrl.mdr_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T7: begin
                    case (opcode)
                        OP_LD: begin
                            ctrl.mdr_out = 1'b1;
                            ctrl.gra     = 1'b1;
                            ctrl.r_in    = 1'b1;
                        end
                        OP_ST: begin
                            ctrl.mdr_out = 1'b1;
                            ctrl.write   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign PCout   = ctrl.pc_out;
    assign MARin   = ctrl.mar_in;
    assign IncPC   = ctrl.inc_pc;
    assign PCin    = ctrl.pc_in;
    assign Read    = ctrl.read;
    assign Write   = ctrl.write;
    assign MDRin   = ctrl.mdr_in;
    assign MDRout  = ctrl.mdr_out;
    assign IRin    = ctrl.ir_in;
    assign Yin     = ctrl.y_in;
    assign Zin     = ctrl.z_in;
    assign Zlowout = ctrl.zlow_out;
    assign BAout   = ctrl.ba_out;
    assign Rin     = ctrl.r_in;
    assign Rout    = ctrl.r_out;
    assign ADD     = ctrl.add;
    assign SUB     = ctrl.sub;
    assign Gra     = ctrl.gra;
    assign Grb     = ctrl.grb;
    assign Grc     = ctrl.grc;
    assign Cout    = ctrl.c_out;

    assign Run   = (state_q != HALT);
    assign state = state_q;

endmodule
